wrr_arbiter: RTL and testbench

Parametrised weighted round-robin arbiter; successor to the fixed 4-requester round-robin arbiter.
- Grants one of NUM_REQ requesters per cycle.
- Holds each grant for up to a per-requester weight (burst quota) before rotating priority.
- Sits between multiple bus masters and a shared single-port resource; grants are registered.

---
 rtl/wrr_arbiter.sv | 140 ++++++++++++++
 tb/tb_wrr_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wrr_arbiter.sv
// ---------------------------------------------------------------------------
// wrr_arbiter
//
// Weighted round-robin arbiter for NUM_REQ bus masters sharing one
// single-port resource. One requester is granted per cycle. A granted
// requester keeps the grant for up to its weight (burst quota) in
// consecutive cycles. After that, priority rotates past it. All outputs
// are registered, so there is no combinational path from req_i to gnt_o.
//
// Parameters:
//   NUM_REQ  number of requesters (>= 2)
//   CNT_W    width of each weight field and of the burst counter
//   ID_W     width of the grant index (derived from NUM_REQ)
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   reset        asynchronous, active-high reset
//   req_i        request vector, bit k belongs to requester k
//   weight_i     per-requester quota, field k = bits [k*CNT_W +: CNT_W].
//                It is sampled only when a grant is issued, and a weight
//                of 0 behaves like 1.
//   gnt_o        registered one-hot grant, all-zero when idle
//   gnt_id_o     index of the granted requester, 0 when idle
//   gnt_valid_o  high exactly when gnt_o is non-zero
// ---------------------------------------------------------------------------
module wrr_arbiter #(
  parameter  int NUM_REQ = 4,
  parameter  int CNT_W   = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*CNT_W-1:0] weight_i,
  output logic [NUM_REQ-1:0]       gnt_o,
  output logic [ID_W-1:0]          gnt_id_o,
  output logic                     gnt_valid_o
);

  // Outcome of each clock edge. These values are listed in priority order.
  typedef enum logic [1:0] {
    DEC_HOLD,
    DEC_ARB,
    DEC_IDLE
  } decision_t;

  // Arbitration state. owner is the last granted requester, and it is also
  // the round-robin pointer. It is not changed in idle cycles, so fairness
  // carries across gaps in traffic.
  logic [ID_W-1:0]    owner;
  logic               busy;
  logic [CNT_W-1:0]   remaining;

  // Winner of the rotating search. This is only meaningful when found is set.
  logic               found;
  logic [ID_W-1:0]    win_id;
  logic [NUM_REQ-1:0] win_onehot;
  logic [CNT_W-1:0]   win_weight;

  decision_t          decision;

  // Rotating priority search. The search starts just after the owner and
  // wraps around, so the owner is examined last. This puts the current
  // owner at the lowest priority when it re-arbitrates. If the owner is the
  // only requester, it still wins, and it gets a new quota without an idle
  // cycle. The winner's weight is selected here so that the quota is
  // sampled on the edge that issues the grant.
  always_comb begin
    int cand;
    found      = 1'b0;
    win_id     = '0;
    win_onehot = '0;
    win_weight = '0;
    cand       = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = int'(owner) + i;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!found && req_i[cand]) begin
        found            = 1'b1;
        win_id           = ID_W'(cand);
        win_onehot[cand] = 1'b1;
        win_weight       = weight_i[cand*CNT_W +: CNT_W];
      end
    end
  end

  // Choose what this edge does. A burst continues only when three things
  // are true: the owner still requests, a grant is live, and more than one
  // quota cycle is left. Otherwise the arbiter searches again. This means a
  // request that drops in the middle of a burst releases the resource on
  // the same edge, and the unused quota is thrown away.
  always_comb begin
    decision = DEC_IDLE;
    if (busy && req_i[owner] && (remaining > CNT_W'(1))) begin
      decision = DEC_HOLD;
    end else if (found) begin
      decision = DEC_ARB;
    end
  end

  // Registered state and outputs. Reset sets the pointer to the last
  // requester, so requester 0 wins the first arbitration after reset.
  // remaining is decremented only while it is above one, so it can never
  // underflow. A weight of zero loads as one, so every grant lasts at
  // least one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_o       <= '0;
      gnt_id_o    <= '0;
      gnt_valid_o <= 1'b0;
      owner       <= ID_W'(NUM_REQ - 1);
      busy        <= 1'b0;
      remaining   <= '0;
    end else begin
      case (decision)
        DEC_HOLD: begin
          remaining <= remaining - CNT_W'(1);
        end
        DEC_ARB: begin
          gnt_o       <= win_onehot;
          gnt_id_o    <= win_id;
          gnt_valid_o <= 1'b1;
          owner       <= win_id;
          busy        <= 1'b1;
          remaining   <= (win_weight == '0) ? CNT_W'(1) : win_weight;
        end
        default: begin
          gnt_o       <= '0;
          gnt_id_o    <= '0;
          gnt_valid_o <= 1'b0;
          busy        <= 1'b0;
          remaining   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wrr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wrr_arbiter
//
// Directed bench for wrr_arbiter with NUM_REQ=4 and CNT_W=4. Each step
// drives req_i. It then waits for one rising edge and checks the registered
// grant 1 ns later. A short random tail checks invariants of the grant:
// one-hot, valid/id consistency, that only requesters get grants, and a
// bound on how long a waiting requester can wait.
// ---------------------------------------------------------------------------
module tb_wrr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int CNT_W   = 4;
  localparam int ID_W    = 2;

  logic                     clk;
  logic                     reset;
  logic [NUM_REQ-1:0]       req_i;
  logic [NUM_REQ*CNT_W-1:0] weight_i;
  logic [NUM_REQ-1:0]       gnt_o;
  logic [ID_W-1:0]          gnt_id_o;
  logic                     gnt_valid_o;

  int vectors;
  int miscompares;

  wrr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_i      (req_i),
    .weight_i   (weight_i),
    .gnt_o      (gnt_o),
    .gnt_id_o   (gnt_id_o),
    .gnt_valid_o(gnt_valid_o)
  );

  // Free-running clock. Rising edges occur at 5, 15, 25 ns, and so on.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // A single comparison point. Every check in this bench goes through here.
  task automatic checkValue(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Compare all three outputs against hand-computed values.
  task automatic checkOutput(input string tag, input logic [3:0] exp_gnt,
                             input logic [1:0] exp_id, input logic exp_valid);
    checkValue({tag, ".gnt"},   32'(gnt_o),       32'(exp_gnt));
    checkValue({tag, ".id"},    32'(gnt_id_o),    32'(exp_id));
    checkValue({tag, ".valid"}, 32'(gnt_valid_o), 32'(exp_valid));
  endtask

  // Drive a request vector. Then wait for the edge that samples it, and
  // wait a further 1 ns so the registered result can be read.
  task automatic applyStimulus(input logic [3:0] req);
    req_i = req;
    @(posedge clk);
    #1;
  endtask

  // Hold reset across two edges and check that the outputs are cleared.
  task automatic doReset(input string tag);
    reset = 1'b1;
    req_i = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput({tag, ".reset"}, 4'h0, 2'd0, 1'b0);
    reset = 1'b0;
  endtask

  // Expected grant for each step of a directed sequence.
  logic [3:0] exp_seq [12];
  logic [1:0] id_seq  [12];
  logic [3:0] rand_req;
  logic [3:0] eff_w   [4];
  int         wait_cnt [4];
  int         bound    [4];

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    req_i       = '0;
    weight_i    = '0;
    #1;
    checkOutput("por", 4'h0, 2'd0, 1'b0);

    // Test 1: all weights are 1 and all four requesters assert.
    // The expected order is a plain rotation starting at requester 0.
    weight_i = 16'h1111;
    doReset("t1");
    req_i = 4'hF;
    #1;
    checkOutput("t1.no_comb_path", 4'h0, 2'd0, 1'b0);
    exp_seq[0:7] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};
    id_seq[0:7]  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(4'hF);
      checkOutput($sformatf("t1.step%0d", i), exp_seq[i], id_seq[i], 1'b1);
    end

    // Test 2: w0=3 and w1=1. Requester 0 gets three cycles, then
    // requester 1 gets one cycle.
    weight_i = 16'h1113;
    doReset("t2");
    exp_seq[0:7] = '{4'h1, 4'h1, 4'h1, 4'h2, 4'h1, 4'h1, 4'h1, 4'h2};
    id_seq[0:7]  = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(4'h3);
      checkOutput($sformatf("t2.step%0d", i), exp_seq[i], id_seq[i], 1'b1);
    end

    // Test 3: w2=4. An idle cycle in the middle drops the grant to zero.
    weight_i = 16'h1413;
    doReset("t3");
    applyStimulus(4'h4);
    checkOutput("t3.step0", 4'h4, 2'd2, 1'b1);
    applyStimulus(4'h4);
    checkOutput("t3.step1", 4'h4, 2'd2, 1'b1);
    applyStimulus(4'h0);
    checkOutput("t3.step2", 4'h0, 2'd0, 1'b0);
    applyStimulus(4'h4);
    checkOutput("t3.step3", 4'h4, 2'd2, 1'b1);

    // Test 4: every weight is zero, so each grant lasts exactly one cycle.
    weight_i = 16'h0000;
    doReset("t4");
    exp_seq[0:3] = '{4'h2, 4'h8, 4'h2, 4'h8};
    id_seq[0:3]  = '{2'd1, 2'd3, 2'd1, 2'd3};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'hA);
      checkOutput($sformatf("t4.step%0d", i), exp_seq[i], id_seq[i], 1'b1);
    end

    // Test 5: a single requester with w0=5. The grant continues across
    // quota reloads without an idle cycle.
    weight_i = 16'h1115;
    doReset("t5");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(4'h1);
      checkOutput($sformatf("t5.step%0d", i), 4'h1, 2'd0, 1'b1);
    end

    // Early release: requester 0 drops in the middle of its burst, so
    // requester 1 is granted at once. When requester 0 is granted again,
    // it gets a full quota of 3.
    weight_i = 16'h1113;
    doReset("rel");
    applyStimulus(4'h3);
    checkOutput("rel.step0", 4'h1, 2'd0, 1'b1);
    applyStimulus(4'h2);
    checkOutput("rel.step1", 4'h2, 2'd1, 1'b1);
    exp_seq[0:3] = '{4'h1, 4'h1, 4'h1, 4'h2};
    id_seq[0:3]  = '{2'd0, 2'd0, 2'd0, 2'd1};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'h3);
      checkOutput($sformatf("rel.step%0d", i + 2), exp_seq[i], id_seq[i], 1'b1);
    end

    // Weight change in the middle of a burst: the burst keeps the quota of
    // 2 it was granted with. The new weight of 1 applies from the next
    // grant onward.
    weight_i = 16'h1112;
    doReset("wchg");
    applyStimulus(4'h3);
    checkOutput("wchg.step0", 4'h1, 2'd0, 1'b1);
    weight_i = 16'h1111;
    exp_seq[0:3] = '{4'h1, 4'h2, 4'h1, 4'h2};
    id_seq[0:3]  = '{2'd0, 2'd1, 2'd0, 2'd1};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'h3);
      checkOutput($sformatf("wchg.step%0d", i + 1), exp_seq[i], id_seq[i], 1'b1);
    end

    // Test 6: asynchronous reset during a burst on requester 2. The outputs
    // clear without a clock edge. Arbitration then restarts at requester 0.
    weight_i = 16'h4444;
    doReset("t6");
    applyStimulus(4'h4);
    checkOutput("t6.burst0", 4'h4, 2'd2, 1'b1);
    applyStimulus(4'hF);
    checkOutput("t6.burst1", 4'h4, 2'd2, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("t6.async_clear", 4'h0, 2'd0, 1'b0);
    #1;
    reset = 1'b0;
    applyStimulus(4'hF);
    checkOutput("t6.restart", 4'h1, 2'd0, 1'b1);

    // Random tail. Weights are fixed during this phase, and one idle cycle
    // lets any burst granted with older weights finish first. A requester
    // that keeps its request up waits at most the sum of the other
    // requesters' effective weights.
    doReset("rand");
    for (int k = 0; k < 4; k++) begin
      eff_w[k] = 4'($urandom_range(0, 5));
      weight_i[k*CNT_W +: CNT_W] = eff_w[k];
      if (eff_w[k] == 4'h0) eff_w[k] = 4'h1;
      wait_cnt[k] = 0;
    end
    for (int k = 0; k < 4; k++) begin
      bound[k] = 0;
      for (int j = 0; j < 4; j++) begin
        if (j != k) bound[k] += int'(eff_w[j]);
      end
    end
    applyStimulus(4'h0);
    for (int i = 0; i < 32; i++) begin
      rand_req = 4'($urandom_range(0, 15));
      applyStimulus(rand_req);
      checkValue($sformatf("rand%0d.onehot", i), 32'($onehot0(gnt_o)), 32'd1);
      checkValue($sformatf("rand%0d.valid", i), 32'(gnt_valid_o), 32'(rand_req != 4'h0));
      checkValue($sformatf("rand%0d.requested", i),
                 32'((gnt_o & ~rand_req) == 4'h0), 32'd1);
      checkValue($sformatf("rand%0d.id", i),
                 32'(gnt_valid_o ? (gnt_o == (4'h1 << gnt_id_o)) : (gnt_id_o == 2'd0)),
                 32'd1);
      for (int k = 0; k < 4; k++) begin
        if (rand_req[k] && !gnt_o[k]) wait_cnt[k]++;
        else wait_cnt[k] = 0;
        checkValue($sformatf("rand%0d.fair%0d", i, k),
                   32'(wait_cnt[k] <= bound[k]), 32'd1);
      end
    end

    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
